// File: rtl/stats_pcie_tlp_collect.sv
// Accumulates per-TLP statistic pulses/widths into saturating per-index counters
// and drains non-zero counters round-robin as increment records on a valid/ready stream.
module stats_pcie_tlp_collect #(
  parameter int ACC_WIDTH    = 16,
  parameter int ID_WIDTH     = 8,
  parameter int STAT_ID_BASE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stat_tlp_mem_rd,
  input  logic                 stat_tlp_mem_wr,
  input  logic                 stat_tlp_io,
  input  logic                 stat_tlp_cfg,
  input  logic                 stat_tlp_msg,
  input  logic                 stat_tlp_cpl,
  input  logic                 stat_tlp_cpl_ur,
  input  logic                 stat_tlp_cpl_ca,
  input  logic                 stat_tlp_atomic,
  input  logic                 stat_tlp_ep,
  input  logic [2:0]           stat_tlp_hdr_dw,
  input  logic [10:0]          stat_tlp_req_dw,
  input  logic [10:0]          stat_tlp_payload_dw,
  input  logic [10:0]          stat_tlp_cpl_dw,
  output logic [ACC_WIDTH-1:0] m_axis_stat_tdata,
  output logic [ID_WIDTH-1:0]  m_axis_stat_tid,
  output logic                 m_axis_stat_tvalid,
  input  logic                 m_axis_stat_tready,
  output logic                 stat_acc_overflow
);

  localparam int                   NUM_STATS = 14;
  localparam logic [3:0]           LAST_IDX  = 4'd13;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX   = '1;

  logic [ACC_WIDTH-1:0] in_vec [NUM_STATS];
  logic [ACC_WIDTH-1:0] acc_q  [NUM_STATS];
  logic [ACC_WIDTH-1:0] acc_d  [NUM_STATS];
  logic [NUM_STATS-1:0] sat_vec;

  logic [3:0]           ptr_q, ptr_d;
  logic [ACC_WIDTH-1:0] tdata_q, tdata_d;
  logic [ID_WIDTH-1:0]  tid_q, tid_d;
  logic                 tvalid_q, tvalid_d;
  logic                 ovf_q, ovf_d;

  logic                 slot_free;
  logic [ACC_WIDTH-1:0] scan_acc;
  logic                 scan_hit;

  assign in_vec[0]  = ACC_WIDTH'(stat_tlp_mem_rd);
  assign in_vec[1]  = ACC_WIDTH'(stat_tlp_mem_wr);
  assign in_vec[2]  = ACC_WIDTH'(stat_tlp_io);
  assign in_vec[3]  = ACC_WIDTH'(stat_tlp_cfg);
  assign in_vec[4]  = ACC_WIDTH'(stat_tlp_msg);
  assign in_vec[5]  = ACC_WIDTH'(stat_tlp_cpl);
  assign in_vec[6]  = ACC_WIDTH'(stat_tlp_cpl_ur);
  assign in_vec[7]  = ACC_WIDTH'(stat_tlp_cpl_ca);
  assign in_vec[8]  = ACC_WIDTH'(stat_tlp_atomic);
  assign in_vec[9]  = ACC_WIDTH'(stat_tlp_ep);
  assign in_vec[10] = ACC_WIDTH'(stat_tlp_hdr_dw);
  assign in_vec[11] = ACC_WIDTH'(stat_tlp_req_dw);
  assign in_vec[12] = ACC_WIDTH'(stat_tlp_payload_dw);
  assign in_vec[13] = ACC_WIDTH'(stat_tlp_cpl_dw);

  assign slot_free = !tvalid_q || m_axis_stat_tready;
  assign scan_acc  = acc_q[ptr_q];
  assign scan_hit  = slot_free && (scan_acc != '0);

  generate
    for (genvar gi = 0; gi < NUM_STATS; gi++) begin : g_acc
      localparam logic [3:0] IDX = 4'(gi);
      logic [ACC_WIDTH:0] sum;
      logic               drain;

      assign sum   = {1'b0, acc_q[gi]} + {1'b0, in_vec[gi]};
      assign drain = scan_hit && (ptr_q == IDX);
      // Draining restarts the count from this cycle's input so no pulse is lost.
      // Overflow flags only the entry into saturation, once per saturation episode.
      assign sat_vec[gi] = !drain && sum[ACC_WIDTH] && (acc_q[gi] != ACC_MAX);
      assign acc_d[gi]   = drain ? in_vec[gi] :
                           (sum[ACC_WIDTH] ? ACC_MAX : sum[ACC_WIDTH-1:0]);
    end
  endgenerate

  always_comb begin
    ptr_d    = ptr_q;
    tdata_d  = tdata_q;
    tid_d    = tid_q;
    tvalid_d = tvalid_q;
    ovf_d    = |sat_vec;
    if (slot_free) begin
      ptr_d = (ptr_q == LAST_IDX) ? 4'd0 : ptr_q + 4'd1;
      if (scan_acc != '0) begin
        tdata_d  = scan_acc;
        tid_d    = ID_WIDTH'(STAT_ID_BASE) + ID_WIDTH'(ptr_q);
        tvalid_d = 1'b1;
      end else begin
        tvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '{default: '0};
      ptr_q    <= '0;
      tdata_q  <= '0;
      tid_q    <= '0;
      tvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      ptr_q    <= ptr_d;
      tdata_q  <= tdata_d;
      tid_q    <= tid_d;
      tvalid_q <= tvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign m_axis_stat_tdata  = tdata_q;
  assign m_axis_stat_tid    = tid_q;
  assign m_axis_stat_tvalid = tvalid_q;
  assign stat_acc_overflow  = ovf_q;

endmodule
